imem_loader: RTL



---
 rtl/imem_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed byte image into
// the 256x16 instruction memory and keeps the core stalled until a load
// completes with a good checksum.
module imem_loader #(
  parameter logic [7:0]  BASE_ADDR      = 8'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [8:0]  words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [8:0]  len;
  logic [7:0]  hi;
  logic [7:0]  csum;
  logic [31:0] tmo_cnt;
  logic        hs;
  logic        tmo_hit;

  // Status outputs are pure functions of state, so start/reset clear them
  // on the same edge that leaves DONE/ERR.
  assign rx_ready   = (state == S_LEN) || (state == S_HI) ||
                      (state == S_LO)  || (state == S_CSUM);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERR);
  assign cpu_hold   = (state != S_DONE);
  assign hs         = rx_valid & rx_ready;
  // Fires on the idle edge that would bring the counter to TIMEOUT_CYCLES.
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && rx_ready && !hs &&
                      (tmo_cnt == TIMEOUT_CYCLES - 1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LEN;
      S_LEN:   if (hs) state_nx = S_HI; else if (tmo_hit) state_nx = S_ERR;
      S_HI:    if (hs) state_nx = S_LO; else if (tmo_hit) state_nx = S_ERR;
      S_LO:    if (hs) state_nx = S_WRITE; else if (tmo_hit) state_nx = S_ERR;
      S_WRITE: state_nx = (words_written + 9'd1 == len) ? S_CSUM : S_HI;
      S_CSUM: begin
        if (hs)           state_nx = (rx_data == csum) ? S_DONE : S_ERR;
        else if (tmo_hit) state_nx = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: length/byte latches, running checksum, write port, timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len           <= '0;
      hi            <= '0;
      csum          <= '0;
      tmo_cnt       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            words_written <= '0;
            csum          <= '0;
            tmo_cnt       <= '0;
          end
        end
        S_LEN: begin
          if (hs) begin
            len  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            csum <= csum ^ rx_data;
          end
        end
        S_HI: begin
          if (hs) begin
            hi   <= rx_data;
            csum <= csum ^ rx_data;
          end
        end
        S_LO: begin
          if (hs) begin
            csum      <= csum ^ rx_data;
            mem_wdata <= {hi, rx_data};
            mem_addr  <= BASE_ADDR + words_written[7:0];
            mem_we    <= 1'b1;
          end
        end
        S_WRITE: words_written <= words_written + 9'd1;
        default: ;
      endcase
      // Idle counter only runs while waiting for a byte; saturates so a
      // disabled timeout never wraps.
      if (rx_ready) begin
        if (hs)                tmo_cnt <= '0;
        else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

endmodule
